// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronised rx, start bit validated at mid-bit,
// data and stop bits sampled at bit centres, byte presented with a valid/ack handshake.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [13:0] HALF_CNT = 14'((CLKS_PER_BIT - 1) / 2);
  localparam logic [13:0] LAST_CNT = 14'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state_q;
  logic [13:0] clk_count_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  shift_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        overrun_q;
  logic        frame_err_q;
  logic        rx_busy_q;

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = rx_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_count_q  <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;

      // Acknowledge first; a delivery in the STOP branch below overrides it.
      if (data_ack && data_valid_q) begin
        data_valid_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          clk_count_q <= '0;
          bit_index_q <= '0;
          if (!rx_s_q) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (clk_count_q == HALF_CNT) begin
            clk_count_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            clk_count_q <= clk_count_q + 14'd1;
          end
        end
        DATA: begin
          if (clk_count_q == LAST_CNT) begin
            clk_count_q          <= '0;
            shift_q[bit_index_q] <= rx_s_q;
            if (bit_index_q == 3'd7) begin
              bit_index_q <= '0;
              state_q     <= STOP;
            end else begin
              bit_index_q <= bit_index_q + 3'd1;
            end
          end else begin
            clk_count_q <= clk_count_q + 14'd1;
          end
        end
        STOP: begin
          if (clk_count_q == LAST_CNT) begin
            clk_count_q <= '0;
            state_q     <= CLEANUP;
            if (rx_s_q) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
              overrun_q    <= data_valid_q && !data_ack;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_count_q <= clk_count_q + 14'd1;
          end
        end
        CLEANUP: begin
          rx_busy_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          clk_count_q <= '0;
          bit_index_q <= '0;
          rx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
